// File: rtl/rr_req_pkg.sv
// rtl/rr_req_pkg.sv - shared types and grant-decode helpers for the rr request frontend
//
// Contents:
//   N_REQ          number of requesting sources (4)
//   req_idx_t      source index type
//   req_vec_t      one bit per source (req / gnt / in_valid vectors)
//   onehot_to_idx  map a grant vector to a source index; rev=1 means bit 3-i grants source i
//   is_onehot      true when exactly one bit of the vector is set
package rr_req_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] req_idx_t;
    typedef logic [3:0] req_vec_t;

    // Only meaningful for a one-hot input; callers qualify with is_onehot().
    function automatic req_idx_t onehot_to_idx(req_vec_t v, bit rev);
        req_idx_t idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) begin
                idx = rev ? req_idx_t'(N_REQ - 1 - i) : req_idx_t'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(req_vec_t v);
        return $onehot(v);
    endfunction

endpackage

// File: rtl/rr_req_frontend_if.sv
// rtl/rr_req_frontend_if.sv - source, arbiter and output stream signals of the rr request frontend
//
// Signals:
//   in_valid/in_ready/in_data  per-source write channels (source i at in_data[i*DATA_W +: DATA_W])
//   req/gnt                    request to and one-hot grant from the round-robin arbiter
//   out_valid/out_ready        registered output stream handshake
//   out_data/out_src           forwarded payload and its source index
//   gnt_err                    sticky malformed-grant flag
// Modports:
//   slave   the frontend itself
//   master  the environment around it (sources, arbiter, downstream sink)
interface rr_req_frontend_if #(
    parameter int DATA_W = 8
);
    import rr_req_pkg::*;

    req_vec_t                  in_valid;
    req_vec_t                  in_ready;
    logic [N_REQ*DATA_W-1:0]   in_data;
    req_vec_t                  req;
    req_vec_t                  gnt;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    req_idx_t                  out_src;
    logic                      gnt_err;

    modport slave (
        input  in_valid, in_data, gnt, out_ready,
        output in_ready, req, out_valid, out_data, out_src, gnt_err
    );

    modport master (
        output in_valid, in_data, gnt, out_ready,
        input  in_ready, req, out_valid, out_data, out_src, gnt_err
    );

endinterface

// File: rtl/rr_req_fifo.sv
// rtl/rr_req_fifo.sv - single-channel synchronous FIFO feeding one arbiter request line
//
// Parameters: DATA_W payload width, DEPTH entries (power of 2, >= 2).
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   push, wr_data  write strobe and payload; ignored while full
//   pop            remove head entry; ignored while empty
//   head           current head entry
//   full, empty    registered occupancy flags
module rr_req_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic do_push;
    logic do_pop;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            // DEPTH is a power of 2, so pointer overflow is the modulo wrap.
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/rr_req_frontend.sv
// rtl/rr_req_frontend.sv - four-source requester frontend for a 4-way round-robin grant FSM
//
// Parameters: DATA_W payload width, DEPTH per-source FIFO depth,
//             GNT_REV grant bit order (1: gnt[3-i] grants source i, 0: gnt[i] grants source i).
// Optional:   RR_REQ_GNT_CHECK_EN builds the sticky gnt_err checker; otherwise gnt_err is 0.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       rr_req_frontend_if.slave: per-source write channels, req/gnt to the arbiter,
//             registered out_valid/out_ready stream with out_data/out_src, gnt_err
module rr_req_frontend
    import rr_req_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int GNT_REV = 1
) (
    input  logic              clk,
    input  logic              rst,
    rr_req_frontend_if.slave  bus
);

    req_vec_t          full;
    req_vec_t          empty;
    req_vec_t          push;
    req_vec_t          pop;
    req_vec_t          req_vec;
    logic [DATA_W-1:0] head [N_REQ];

    req_idx_t          gnt_idx;
    logic              gnt_ok;
    logic              fire;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    req_idx_t          out_src_q,   out_src_d;

    for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
        rr_req_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push    (push[i]),
            .wr_data (bus.in_data[i*DATA_W +: DATA_W]),
            .pop     (pop[i]),
            .head    (head[i]),
            .full    (full[i]),
            .empty   (empty[i])
        );
    end

    // Both come straight from registered FIFO flags: no in_valid -> req path,
    // and a push into an empty FIFO only becomes grantable the next cycle.
    assign req_vec      = ~empty;
    assign bus.req      = req_vec;
    assign bus.in_ready = ~full;

    always_comb begin
        gnt_idx = onehot_to_idx(bus.gnt, GNT_REV != 0);
        gnt_ok  = is_onehot(bus.gnt);
        // A grant during a stall or to an empty source is simply dropped;
        // the arbiter re-grants later because req stays up.
        fire    = gnt_ok && !empty[gnt_idx] && (!out_valid_q || bus.out_ready);

        push = bus.in_valid & ~full;
        pop  = '0;
        if (fire) begin
            pop[gnt_idx] = 1'b1;
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (fire) begin
            out_valid_d = 1'b1;
            out_data_d  = head[gnt_idx];
            out_src_d   = gnt_idx;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

`ifdef RR_REQ_GNT_CHECK_EN
    logic gnt_err_q, gnt_err_d;

    // Flags any cycle with outstanding requests where the grant is not one-hot
    // or points at a source that is not requesting.
    always_comb begin
        gnt_err_d = gnt_err_q;
        if ((req_vec != '0) && (!gnt_ok || !req_vec[gnt_idx])) begin
            gnt_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_err_q <= 1'b0;
        end else begin
            gnt_err_q <= gnt_err_d;
        end
    end

    assign bus.gnt_err = gnt_err_q;
`else
    assign bus.gnt_err = 1'b0;
`endif

endmodule

// File: doc/rr_req_frontend.md
Name: rr_req_frontend

Overview:
- Requester-side companion to the 4-way round-robin grant FSM.
- Buffers traffic from four sources in per-source FIFOs and drives req[3:0] from FIFO occupancy.
- Consumes the one-hot gnt[3:0] returned by the arbiter and forwards the granted source's head entry to a single registered valid/ready output stream tagged with its source index.

Parameters:
- DATA_W, 8, payload width per entry.
- DEPTH, 4, entries per source FIFO; power of 2, minimum 2.
- GNT_REV, 1, grant bit order. 1: gnt[3-i] grants source i, so 4'b1000 grants source 0. 0: gnt[i] grants source i.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  4  per-source write valid.
- in_ready  out  4  per-source write ready; in_ready[i] = !full[i].
- in_data  in  4*DATA_W  source i occupies bits [i*DATA_W +: DATA_W].
- req  out  4  request to arbiter; req[i] = !empty[i].
- gnt  in  4  grant from arbiter; expected one-hot.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  forwarded payload.
- out_src  out  2  source index of out_data.
- gnt_err  out  1  sticky malformed-grant flag; tied 0 without the optional feature.

Behaviour:
- Reset values: all FIFOs empty, req=0, in_ready=4'b1111, out_valid=0, out_data=0, out_src=0, gnt_err=0. Reset mid-operation flushes all buffered entries and any pending output; nothing is replayed afterwards.
- Push: FIFO i writes in_data slice i when in_valid[i] && in_ready[i]. Each FIFO has a count of width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
- req[i] derives only from registered FIFO state, so no combinational path exists from in_valid to req.
- Grant decode:
  - gnt is remapped per GNT_REV to a source index g.
  - gnt is valid only if exactly one bit is set. gnt=0 or multi-hot causes no pop.
- Pop (the fire condition): gnt valid && !empty[g] && (!out_valid || out_ready).
  - On fire: FIFO g pops its head entry; next cycle out_valid=1, out_data=head, out_src=g.
- Latency: gnt sampled at edge t produces out_valid at t+1. The input-push-to-req delay is 1 cycle.
- Output hold: while out_valid && !out_ready, out_data and out_src are stable and no pop occurs. A grant arriving during a stall is dropped; the entry stays queued and req stays high.
- When out_ready=1 and no fire occurs, out_valid clears next cycle.
- Grant to an empty source: ignored, no pop. This covers an arbiter parked on its last owner.
- Simultaneous push and pop on the same FIFO:
  - Allowed; count is unchanged.
  - A full FIFO still refuses the push, because in_ready is from registered full.
  - An empty FIFO cannot pop in the same cycle as its first push; the entry becomes eligible next cycle.
- Throughput: one entry per cycle sustained when out_ready=1 and the arbiter grants a non-empty source each cycle.
- Ordering: FIFO order is preserved per source. There is no cross-source ordering guarantee.

Optional Feature:
- Macro: RR_REQ_GNT_CHECK_EN.
- Defined:
  - gnt_err sets on any cycle where gnt is not one-hot (including 0) while req != 0.
  - gnt_err also sets on any grant to a source whose req is 0 while another req is set.
  - gnt_err clears only on rst.
- Undefined: gnt_err is constant 0 and no check logic is built. Datapath behaviour is identical either way.

Decomposition:
- Package rr_req_pkg:
  - N_REQ=4.
  - typedef req_idx_t as logic [1:0].
  - typedef req_vec_t as logic [3:0].
  - function onehot_to_idx(req_vec_t, bit rev) returning req_idx_t.
  - function is_onehot(req_vec_t).
- Sub-module rr_req_fifo: single-channel synchronous FIFO, parameterised on DATA_W/DEPTH, with push/pop/full/empty/head. Instantiated 4x in a generate loop.

Test Plan:
- Reset then idle: push 0xA5 to source 2 at cycle 0 -> req=4'b0100 at cycle 1; gnt=4'b0010 (GNT_REV=1) at cycle 1 -> out_valid=1, out_data=0xA5, out_src=2 at cycle 2; req returns to 0.
- Fill source 0 with 0x10..0x13 (DEPTH=4) -> in_ready[0]=0, and a fifth push is refused. With gnt held at 4'b1000 and out_ready=1 -> outputs 0x10,0x11,0x12,0x13 on consecutive cycles, with in_ready[0] reasserting after the first pop.
- Backpressure: out_ready=0 with one entry valid and gnt pointing at a non-empty source -> out_data stable, no pop, count unchanged. out_ready=1 -> pop resumes next cycle.
- Malformed grants: gnt=4'b0000 and gnt=4'b1100 with all sources non-empty -> no pops. With RR_REQ_GNT_CHECK_EN, gnt_err=1 and it stays 1 until rst.
- Connected to the 4-way round-robin arbiter: all four sources preloaded with 3 entries each -> out_src sequence rotates 1,2,3,0,… and all 12 entries are delivered in per-source order.
- Async rst asserted mid-stream with 2 entries queued and out_valid=1 -> out_valid=0, req=0, in_ready=4'b1111 immediately; no stale data after reset deasserts.
